// File: rtl/rst_cipher_pkg.sv
// Shared types, constants and table helpers for rst_cipher/rst_decipher.
// Optional macro RST_DECIPHER_CASE_FOLD_EN folds A-Z to a-z in norm().
package rst_cipher_pkg;

   localparam logic [7:0] CH_NUL = 8'h00;
   localparam logic [7:0] CH_0   = 8'h30;
   localparam logic [7:0] CH_9   = 8'h39;
   localparam logic [7:0] CH_UA  = 8'h41;
   localparam logic [7:0] CH_UZ  = 8'h5A;
   localparam logic [7:0] CH_LA  = 8'h61;
   localparam logic [7:0] CH_LZ  = 8'h7A;

   localparam int NKEY = 12;
   localparam int NHDR = 6;

   typedef logic [11:0][7:0] key_t;
   typedef logic [5:0][7:0]  hdr_t;

   typedef enum logic {
      ST_NO_KEY,
      ST_KEYED
   } state_t;

   // Header slot i (0 = header 1) takes key char k<MAP[i]>
   localparam logic [5:0][3:0] ROW_KIDX =
      {4'd6, 4'd4, 4'd8, 4'd2, 4'd10, 4'd0};
   localparam logic [5:0][3:0] COL_KIDX =
      {4'd7, 4'd5, 4'd9, 4'd3, 4'd11, 4'd1};

   function automatic logic is_alnum(input logic [7:0] ch);
      return (ch >= CH_0  && ch <= CH_9)  ||
             (ch >= CH_UA && ch <= CH_UZ) ||
             (ch >= CH_LA && ch <= CH_LZ);
   endfunction

   // Canonical form used for repeat checks and header matching
   function automatic logic [7:0] norm(input logic [7:0] ch);
`ifdef RST_DECIPHER_CASE_FOLD_EN
      if (ch >= CH_UA && ch <= CH_UZ)
         return ch + 8'd32;
      return ch;
`else
      return ch;
`endif
   endfunction

   // Body is a..z then 0..9, row-major, 0-based r/c
   function automatic logic [7:0] body_char(
      input logic [2:0] r,
      input logic [2:0] c
   );
      logic [7:0] n;
      n = 8'(r) * 8'd6 + 8'(c);
      if (n < 8'd26)
         return CH_LA + n;
      return CH_0 + (n - 8'd26);
   endfunction

endpackage

// File: rtl/rst_header_lookup.sv
// Six-entry header search: returns 0-based index and hit of query char.
// Ports: hdr (6 header chars), query (char), idx (3b), hit.
module rst_header_lookup
   import rst_cipher_pkg::*;
(
   input  hdr_t       hdr,
   input  logic [7:0] query,
   output logic [2:0] idx,
   output logic       hit
);

   always_comb begin
      idx = 3'd0;
      hit = 1'b0;
      // Descending scan so the lowest matching slot wins
      for (int i = NHDR - 1; i >= 0; i--) begin
         if (norm(hdr[i]) == norm(query)) begin
            idx = 3'(i);
            hit = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rst_decipher.sv
// Rotating-header 6x6 decipher, one char per cycle, registered outputs.
// Ports: clk, rst_n, key_valid/key, ctxt_valid/ctxt_str -> ptxt_char,
//   ptxt_ready, err_invalid_key, err_key_not_installed, err_invalid_ctxt.
// Optional macro RST_DECIPHER_CASE_FOLD_EN (case-insensitive key/match).
module rst_decipher
   import rst_cipher_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        key_valid,
   input  key_t        key,
   input  logic        ctxt_valid,
   input  logic [15:0] ctxt_str,
   output logic [7:0]  ptxt_char,
   output logic        ptxt_ready,
   output logic        err_invalid_key,
   output logic        err_key_not_installed,
   output logic        err_invalid_ctxt
);

   state_t     state_q, state_d;
   hdr_t       row_q, row_d;
   hdr_t       col_q, col_d;
   hdr_t       row_load, col_load;
   logic       key_ok;
   logic [2:0] r_idx, c_idx;
   logic       r_hit, c_hit;
   logic [7:0] char_d;
   logic       rdy_d, eik_d, eknk_d, eic_d;

   // Key char kN sits at key[11-N]
   always_comb begin
      row_load = '0;
      col_load = '0;
      for (int i = 0; i < NHDR; i++) begin
         row_load[i] = key[4'd11 - ROW_KIDX[i]];
         col_load[i] = key[4'd11 - COL_KIDX[i]];
      end
   end

   always_comb begin
      key_ok = 1'b1;
      for (int i = 0; i < NKEY; i++) begin
         if (!is_alnum(key[i]))
            key_ok = 1'b0;
         for (int j = i + 1; j < NKEY; j++) begin
            if (norm(key[i]) == norm(key[j]))
               key_ok = 1'b0;
         end
      end
   end

   rst_header_lookup u_row (
      .hdr   (row_q),
      .query (ctxt_str[15:8]),
      .idx   (r_idx),
      .hit   (r_hit)
   );

   rst_header_lookup u_col (
      .hdr   (col_q),
      .query (ctxt_str[7:0]),
      .idx   (c_idx),
      .hit   (c_hit)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_NO_KEY;
         row_q   <= '0;
         col_q   <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
      end
   end

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      char_d  = CH_NUL;
      rdy_d   = 1'b0;
      eik_d   = 1'b0;
      eknk_d  = 1'b0;
      eic_d   = 1'b0;
      if (key_valid) begin
         // Same-cycle ciphertext is silently dropped
         if (key_ok) begin
            state_d = ST_KEYED;
            row_d   = row_load;
            col_d   = col_load;
         end else begin
            state_d = ST_NO_KEY;
            eik_d   = 1'b1;
         end
      end else if (ctxt_valid) begin
         unique case (state_q)
            ST_NO_KEY: eknk_d = 1'b1;
            ST_KEYED: begin
               if (r_hit && c_hit) begin
                  char_d = body_char(r_idx, c_idx);
                  rdy_d  = 1'b1;
                  // Slot 6 wraps to slot 1, others shift up
                  row_d  = {row_q[4:0], row_q[5]};
                  col_d  = {col_q[4:0], col_q[5]};
               end else begin
                  eic_d = 1'b1;
               end
            end
            default: state_d = ST_NO_KEY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptxt_char             <= CH_NUL;
         ptxt_ready            <= 1'b0;
         err_invalid_key       <= 1'b0;
         err_key_not_installed <= 1'b0;
         err_invalid_ctxt      <= 1'b0;
      end else begin
         ptxt_char             <= char_d;
         ptxt_ready            <= rdy_d;
         err_invalid_key       <= eik_d;
         err_key_not_installed <= eknk_d;
         err_invalid_ctxt      <= eic_d;
      end
   end

endmodule

// File: tb/tb_rst_decipher.sv
// Directed scoreboard bench for rst_decipher, including a round trip
// through a behavioural encryptor model.
module tb_rst_decipher;
   import rst_cipher_pkg::*;

   typedef logic [11:0] exp_t;

   logic        clk;
   logic        rst_n;
   logic        key_valid;
   key_t        key;
   logic        ctxt_valid;
   logic [15:0] ctxt_str;
   logic [7:0]  ptxt_char;
   logic        ptxt_ready;
   logic        err_invalid_key;
   logic        err_key_not_installed;
   logic        err_invalid_ctxt;

   exp_t  sb[$];
   string tg[$];
   int    n_cmp = 0;
   int    n_bad = 0;

   logic [7:0] m_row[6];
   logic [7:0] m_col[6];

   rst_decipher dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .key_valid             (key_valid),
      .key                   (key),
      .ctxt_valid            (ctxt_valid),
      .ctxt_str              (ctxt_str),
      .ptxt_char             (ptxt_char),
      .ptxt_ready            (ptxt_ready),
      .err_invalid_key       (err_invalid_key),
      .err_key_not_installed (err_key_not_installed),
      .err_invalid_ctxt      (err_invalid_ctxt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t e_ok(input logic [7:0] ch);
      return {4'b1000, ch};
   endfunction

   localparam exp_t E_NONE = 12'h000;
   localparam exp_t E_IK   = 12'h400;
   localparam exp_t E_NK   = 12'h200;
   localparam exp_t E_IC   = 12'h100;

   task automatic check();
      exp_t  e;
      exp_t  o;
      string t;
      o = {ptxt_ready, err_invalid_key,
           err_key_not_installed, err_invalid_ctxt, ptxt_char};
      n_cmp++;
      if (sb.size() == 0) begin
         n_bad++;
         $error("FAIL scoreboard_empty observed=%h required=entry", o);
      end else begin
         e = sb.pop_front();
         t = tg.pop_front();
         assert (o === e) else begin
            n_bad++;
            $error("FAIL %s observed=%h required=%h", t, o, e);
         end
      end
   endtask

   task automatic step(
      input logic        kv,
      input key_t        k,
      input logic        cv,
      input logic [15:0] c,
      input exp_t        e,
      input string       t
   );
      key_valid  = kv;
      key        = k;
      ctxt_valid = cv;
      ctxt_str   = c;
      sb.push_back(e);
      tg.push_back(t);
      @(posedge clk);
      #1;
      check();
   endtask

   task automatic model_load(input key_t k);
      m_row[0] = k[11];  m_col[0] = k[10];
      m_row[1] = k[1];   m_col[1] = k[0];
      m_row[2] = k[9];   m_col[2] = k[8];
      m_row[3] = k[3];   m_col[3] = k[2];
      m_row[4] = k[7];   m_col[4] = k[6];
      m_row[5] = k[5];   m_col[5] = k[4];
   endtask

   task automatic model_enc(
      input  logic [7:0]  p,
      output logic [15:0] ct,
      output logic [7:0]  lc
   );
      int n;
      logic [7:0] tr, tc;
      lc = (p >= "A" && p <= "Z") ? p + 8'd32 : p;
      n  = (lc >= "a") ? int'(lc - "a") : int'(lc - "0") + 26;
      ct = {m_row[n / 6], m_col[n % 6]};
      tr = m_row[5];
      tc = m_col[5];
      for (int i = 5; i > 0; i--) begin
         m_row[i] = m_row[i - 1];
         m_col[i] = m_col[i - 1];
      end
      m_row[0] = tr;
      m_col[0] = tc;
   endtask

   initial begin
      key_t        k1;
      key_t        k2;
      key_t        kz;
      string       pt;
      logic [15:0] ct;
      logic [7:0]  lc;

      k1 = "abcdefghijkl";
      k2 = "aB3xYz9Qw1Kp";
      kz = '0;
      pt = "abcdefghijklmnopqrstuvwxyzABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";

      rst_n      = 1'b0;
      key_valid  = 1'b0;
      key        = kz;
      ctxt_valid = 1'b0;
      ctxt_str   = 16'h0;
      repeat (2) @(posedge clk);
      #1;
      sb.push_back(E_NONE);
      tg.push_back("reset_outputs");
      check();
      @(negedge clk);
      rst_n = 1'b1;

      step(0, kz, 1, "ab", E_NK, "no_key_ctxt");
      step(0, kz, 0, 16'h0, E_NONE, "idle_clear");

      step(1, "abcdabcdabcd", 0, 16'h0, E_IK, "key_repeat");
      step(1, "abcdefghi?kl", 0, 16'h0, E_IK, "key_badchar");
      step(0, kz, 1, "ab", E_NK, "still_no_key");

      step(1, k1, 0, 16'h0, E_NONE, "key_install");
      step(0, kz, 1, "ab", e_ok("a"), "b2b_1");
      step(0, kz, 1, "ab", e_ok("h"), "b2b_2");
      step(0, kz, 1, "gh", e_ok("h"), "b2b_3");
      step(0, kz, 0, 16'h0, E_NONE, "b2b_idle");

      step(1, k1, 0, 16'h0, E_NONE, "rekey");
      step(0, kz, 1, "zz", E_IC, "ctxt_miss");
      step(0, kz, 1, "ab", e_ok("a"), "no_rotate");
      step(0, kz, 1, "az", E_IC, "col_miss");
      step(1, k1, 0, 16'h0, E_NONE, "rekey_fresh");
      step(0, kz, 1, "gh", e_ok("9"), "last_cell");

      step(1, k1, 0, 16'h0, E_NONE, "rekey_pre_rst");
      step(0, kz, 1, "ab", e_ok("a"), "pre_rst");
      rst_n = 1'b0;
      #1;
      sb.push_back(E_NONE);
      tg.push_back("async_rst");
      check();
      @(negedge clk);
      rst_n = 1'b1;
      step(0, kz, 1, "ab", E_NK, "post_rst_nokey");
      step(1, k1, 0, 16'h0, E_NONE, "post_rst_key");
      step(0, kz, 1, "ab", e_ok("a"), "post_rst_dec");

      step(1, k1, 1, "gh", E_NONE, "same_cycle_drop");
      step(0, kz, 1, "ab", e_ok("a"), "after_drop");
      step(1, "abcdabcdabcd", 1, "ab", E_IK, "same_cycle_bad");
      step(0, kz, 1, "ab", E_NK, "bad_then_nokey");

      step(1, k2, 0, 16'h0, E_NONE, "rt_key");
      model_load(k2);
      for (int i = 0; i < pt.len(); i++) begin
         model_enc(pt[i], ct, lc);
         step(0, kz, 1, ct, e_ok(lc), "round_trip");
      end
      step(0, kz, 0, 16'h0, E_NONE, "rt_idle");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/rst_decipher.md
# rst_decipher

Receive-side counterpart of `rst_cipher`. It recovers one plaintext character per cycle from a 16-bit ciphertext pair `{row header, column header}`, using the same 12-character key and the same 6×6 rotating-header table as the encryptor. It sits after the ciphertext channel and runs in lock-step with `rst_cipher`: after every successfully decoded character it applies the header rotation that `rst_cipher` applied after encrypting that character.

## Interface
- No parameters; table geometry and character constants are fixed in `rst_cipher_pkg`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `key_valid` in 1: request to install `key` this cycle.
- `key` in [11:0][7:0]: key string; `key[11]` is string char k0, `key[0]` is k11.
- `ctxt_valid` in 1: `ctxt_str` is valid this cycle.
- `ctxt_str` in 16: [15:8] is the row-header char, [7:0] is the column-header char.
- `ptxt_char` out 8: decoded char; always a lowercase letter or a digit; NUL when there is no valid result.
- `ptxt_ready` out 1: one-cycle pulse; `ptxt_char` holds a valid result.
- `err_invalid_key` out 1: one-cycle pulse; a key install was rejected.
- `err_key_not_installed` out 1: one-cycle pulse; `ctxt_valid` arrived while no key was installed.
- `err_invalid_ctxt` out 1: one-cycle pulse; a header char was not found in the current headers.

## Operation
- FSM has two states.
  - NO_KEY: reset state. No key installed; decoding is disabled.
  - KEYED: a legal key is installed; decoding is enabled.
- Key install has priority. `key_valid` is honoured in either state.
  - A key is legal when all 12 chars are in 0-9, A-Z or a-z and there are no repeats.
  - Legal key: load the headers and go to KEYED. This discards any rotation history.
  - Illegal key: pulse `err_invalid_key` and go to NO_KEY.
- Header load from key chars:
  - Rows 1..6 = k0, k10, k2, k8, k4, k6.
  - Columns 1..6 = k1, k11, k3, k9, k5, k7.
- Table body is constant.
  - Rows 1-4 and row 5 columns 1-2 hold `a`..`z`, filled row-major.
  - Row 5 columns 3-6 hold `0`..`3`; row 6 holds `4`..`9`.
- Decode, in KEYED with `ctxt_valid`=1 and `key_valid`=0:
  - Find row r whose header equals [15:8] and column c whose header equals [7:0].
  - Both found: `ptxt_char` = body[r][c]; pulse `ptxt_ready`; then rotate the headers.
  - Either not found: `ptxt_char` = NUL; pulse `err_invalid_ctxt`; no rotation.
- Rotation:
  - Columns: new col[i] = col[i-1] for i = 2..6; new col[1] = old col[6].
  - Rows: rotate the same way.
- `ctxt_valid` in NO_KEY: pulse `err_key_not_installed`; `ptxt_char` = NUL.
- `ctxt_valid` with `key_valid` in the same cycle: the ciphertext is dropped, with no output and no flag.
- At most one of `ptxt_ready` and the three err flags is high in any cycle.

## Timing
- Reset values:
  - State = NO_KEY; headers = NUL.
  - `ptxt_char` = 8'h00.
  - `ptxt_ready` and all err flags = 0.
- Asynchronous reset mid-stream returns to NO_KEY immediately. A key must be installed again before decoding.
- All outputs are registered.
  - Latency: 1 cycle from the sampled `ctxt_valid` or `key_valid` edge.
  - Outputs return to NUL/0 in the next cycle unless a new request is sampled.
- Throughput: 1 char per cycle, back-to-back. Rotation is in effect for the very next cycle's ciphertext.
- The key takes effect from the cycle after `key_valid`. Key validation and lookups are single-cycle combinational.
- No backpressure. The downstream consumer must accept every `ptxt_ready` pulse.

## Configuration
- `RST_DECIPHER_CASE_FOLD_EN`.
  - Defined: A-Z are folded to a-z before the key repeat check and before header matching. With this, "aB…" and "Ab…" are equivalent, and "aA…" is an illegal key.
  - Undefined: exact byte compares everywhere.
- Must match the `rst_cipher` build for round-trip correctness.

## Structure
- `rst_cipher_pkg` (shared with `rst_cipher`) holds:
  - char constants: NUL, '0', '9', 'A', 'Z', 'a', 'z';
  - `key_t` as [11:0][7:0] and `hdr_t` as [5:0][7:0];
  - the key-to-header index map;
  - a `body_char(r, c)` function;
  - an `is_alnum` function.
- One sub-module, `rst_header_lookup`: a 6-entry header plus a query char give a 3-bit index and a `hit` bit. It is instantiated twice, once for rows and once for columns.

## Test plan
- Reset, then `ctxt_str` = "ab" with no key → `err_key_not_installed` = 1, `ptxt_char` = 8'h00, `ptxt_ready` = 0.
- Key "abcdabcdabcd", then key "abcdefghi?kl" → `err_invalid_key` pulses twice; state stays NO_KEY.
- Key "abcdefghijkl", then back-to-back "ab", "ab", "gh" → `a`, `h`, then a result consistent with the rotated headers; `ptxt_ready` pulses on three consecutive cycles.
- Key "abcdefghijkl", then "zz" and then "ab" → `err_invalid_ctxt` for "zz", then `a`, proving no rotation occurred. Fresh key, then "gh" → `9`.
- Assert `rst_n`=0 mid-stream, reinstall the key, send "ab" → `a`. In the same-cycle `key_valid` + `ctxt_valid` case: no output pulse.
- Round trip: `rst_cipher` with key "aB3xYz9Qw1Kp" encrypts `a`..`z`, `A`..`Z`, `0`..`9`; feed its output to `rst_decipher` → the lowercase/digit stream matches char for char, with `ptxt_ready` on each.
